// File: rtl/vld_rdy_rr_arbiter.sv
// Burst-granular round-robin arbiter: NUM_REQ valid-ready streams share one registered output.
// Define VRA_PKT_LOCK_EN to hold each grant until the frame's last beat (whole-frame atomicity).
module vld_rdy_rr_arbiter #(
  parameter  int DATA_WIDTH = 24,
  parameter  int NUM_REQ    = 4,
  parameter  int BURST_LEN  = 16,
  localparam int SEL_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [SEL_W-1:0]              out_src
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_reg, state_next;
  logic [SEL_W-1:0]      grant_reg, grant_next;
  logic [SEL_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [7:0]            beat_cnt_reg, beat_cnt_next;
  logic [SEL_W-1:0]      pick, cand;
  logic                  pick_vld;
  logic                  accept;
  logic                  release_grant;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Walk offsets from the far end down so the requester closest to rr_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = SEL_W'((32'(rr_ptr_reg) + 32'(k)) % NUM_REQ);
      if (in_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (state_reg == GRANT) begin
      in_ready[grant_reg] = ~out_valid | out_ready;
    end
  end

  assign accept = in_valid[grant_reg] & in_ready[grant_reg];

`ifdef VRA_PKT_LOCK_EN
  assign release_grant = accept & in_last[grant_reg];
`else
  assign release_grant = (accept & (in_last[grant_reg] | (beat_cnt_reg == 8'(BURST_LEN - 1))))
                       | ~in_valid[grant_reg];
`endif

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_vld) begin
          state_next    = GRANT;
          grant_next    = pick;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
        end
        if (release_grant) begin
          state_next  = IDLE;
          rr_ptr_next = (32'(grant_reg) == NUM_REQ - 1) ? '0 : grant_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // A push wins over a pop, so back-to-back beats keep out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= data_arr[grant_reg];
      out_last  <= in_last[grant_reg];
      out_src   <= grant_reg;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vld_rdy_rr_arbiter.sv
// Scoreboard bench for vld_rdy_rr_arbiter: per-source expected queues filled at stimulus time.
// A second instance with BURST_LEN=4 covers burst splitting (honours VRA_PKT_LOCK_EN).
module tb_vld_rdy_rr_arbiter;
  localparam int DW = 24;
  localparam int NR = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    in_valid, in_ready, in_last;
  logic [NR*DW-1:0] in_data;
  logic             out_valid, out_ready, out_last;
  logic [DW-1:0]    out_data;
  logic [SW-1:0]    out_src;

  logic [NR-1:0]    b_in_valid, b_in_ready, b_in_last;
  logic [NR*DW-1:0] b_in_data;
  logic             b_out_valid, b_out_ready, b_out_last;
  logic [DW-1:0]    b_out_data;
  logic [SW-1:0]    b_out_src;

  vld_rdy_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src)
  );

  vld_rdy_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_src(b_out_src)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          gap;
  } beat_t;

  beat_t src_q [NR][$];
  beat_t exp_q [NR][$];
  int    log_cyc [$];
  int    log_src [$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic          hold_prev;
  logic [DW-1:0] hold_data;
  logic          hold_last;
  logic [SW-1:0] hold_src;

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0 && !src_q[i][0].gap) begin
        in_valid[i]          = 1'b1;
        in_data[i*DW +: DW]  = src_q[i][0].data;
        in_last[i]           = src_q[i][0].last;
      end else begin
        in_valid[i]          = 1'b0;
        in_data[i*DW +: DW]  = '0;
        in_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic push_beat(input int s, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l; b.gap = 1'b0;
    src_q[s].push_back(b);
    exp_q[s].push_back(b);
  endtask

  task automatic push_gap(input int s);
    beat_t b;
    b.data = '0; b.last = 1'b0; b.gap = 1'b1;
    src_q[s].push_back(b);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: observe at negedge, update stimulus 1 time unit after posedge.
  task automatic tick();
    logic [NR-1:0] acc;
    @(negedge clk);
    cyc++;
    if (hold_prev) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== hold_data || out_last !== hold_last || out_src !== hold_src) begin
        tests_failed++;
        $display("FAIL hold_stable: got v=%0b d=%h l=%0b s=%0d, need v=1 d=%h l=%0b s=%0d",
                 out_valid, out_data, out_last, out_src, hold_data, hold_last, hold_src);
      end
    end
    if (out_valid && out_ready) begin
      tests_run++;
      $display("[TB] cyc=%0d beat src=%0d data=%h last=%0b", cyc, out_src, out_data, out_last);
      if (exp_q[out_src].size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_extra: got src=%0d data=%h, need no beat", out_src, out_data);
      end else begin
        beat_t e;
        e = exp_q[out_src].pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          tests_failed++;
          $display("FAIL scoreboard_beat: got src=%0d data=%h last=%0b, need data=%h last=%0b",
                   out_src, out_data, out_last, e.data, e.last);
        end
      end
      log_cyc.push_back(cyc);
      log_src.push_back(int'(out_src));
    end
    hold_prev = out_valid && !out_ready;
    hold_data = out_data;
    hold_last = out_last;
    hold_src  = out_src;
    tests_run++;
    if ($countones(in_ready) > 1) begin
      tests_failed++;
      $display("FAIL ready_onehot: got in_ready=%b, need at most one bit", in_ready);
    end
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
      else if (src_q[i].size() > 0 && src_q[i][0].gap) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!all_empty() && n < budget) begin
      tick();
      n++;
    end
    tests_run++;
    if (!all_empty()) begin
      tests_failed++;
      $display("FAIL %s_timeout: got pending beats after %0d cycles, need none", name, budget);
    end
    tick();
    tick();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    log_cyc.delete();
    log_src.delete();
    hold_prev = 1'b0;
    in_valid = '0; in_data = '0; in_last = '0;
    b_in_valid = '0; b_in_data = '0; b_in_last = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    out_ready   = 1'b1;
    b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_all();
    out_ready = 1'b0;
    b_out_ready = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b, need 0", out_valid); end
    tests_run++;
    if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %h, need 0", out_data); end
    tests_run++;
    if (out_last !== 1'b0 || out_src !== '0) begin
      tests_failed++; $display("FAIL reset_last_src: got last=%0b src=%0d, need 0 0", out_last, out_src);
    end
    tests_run++;
    if (in_ready !== '0) begin tests_failed++; $display("FAIL reset_in_ready: got %b, need 0000", in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_stream();
    int first;
    do_reset();
    first = cyc + 1;
    for (int k = 1; k <= 5; k++) push_beat(2, DW'(k), k == 5);
    drive();
    wait_idle(40, "single");
    tests_run++;
    if (log_src.size() != 5) begin
      tests_failed++; $display("FAIL single_count: got %0d beats, need 5", log_src.size());
    end
    for (int k = 0; k < log_src.size() && k < 5; k++) begin
      tests_run++;
      if (log_src[k] != 2 || log_cyc[k] != first + 2 + k) begin
        tests_failed++;
        $display("FAIL single_beat%0d: got src=%0d cyc=%0d, need src=2 cyc=%0d", k, log_src[k], log_cyc[k], first + 2 + k);
      end
    end
  endtask

  task automatic test_round_robin();
    int ord [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int s = 0; s < NR; s++)
      for (int k = 0; k < 3; k++) push_beat(s, DW'((s << 16) | k), k == 2);
    for (int k = 0; k < 3; k++) push_beat(0, DW'(32'h100 | k), k == 2);
    drive();
    wait_idle(100, "rr");
    tests_run++;
    if (log_src.size() != 15) begin
      tests_failed++; $display("FAIL rr_count: got %0d beats, need 15", log_src.size());
    end
    for (int p = 0; p < log_src.size() && p < 15; p++) begin
      tests_run++;
      if (log_src[p] != ord[p / 3]) begin
        tests_failed++; $display("FAIL rr_src%0d: got %0d, need %0d", p, log_src[p], ord[p / 3]);
      end
      if (p > 0) begin
        tests_run++;
        if (log_cyc[p] != log_cyc[p-1] + ((p % 3 == 0) ? 2 : 1)) begin
          tests_failed++;
          $display("FAIL rr_spacing%0d: got gap %0d, need %0d", p, log_cyc[p] - log_cyc[p-1], (p % 3 == 0) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_burst_split();
    logic [DW-1:0] bexp [$];
    int bcyc [$];
    int grp [$];
    int idx = 0;
    logic acc;
`ifdef VRA_PKT_LOCK_EN
    int want [] = '{10};
`else
    int want [] = '{4, 4, 2};
`endif
    do_reset();
    for (int k = 1; k <= 10; k++) bexp.push_back(DW'(k));
    b_in_valid[0]    = 1'b1;
    b_in_data[DW-1:0] = DW'(1);
    for (int n = 0; n < 60 && !(idx >= 10 && bexp.size() == 0); n++) begin
      @(negedge clk);
      if (b_out_valid && b_out_ready) begin
        tests_run++;
        $display("[TB] burst beat n=%0d data=%h last=%0b", n, b_out_data, b_out_last);
        if (bexp.size() == 0 || b_out_data !== bexp[0] || b_out_last !== 1'b0) begin
          tests_failed++;
          $display("FAIL burst_beat: got data=%h last=%0b, need data=%h last=0", b_out_data, b_out_last,
                   (bexp.size() > 0) ? bexp[0] : '0);
        end
        if (bexp.size() > 0) void'(bexp.pop_front());
        bcyc.push_back(n);
      end
      acc = b_in_valid[0] && b_in_ready[0];
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (idx < 10) b_in_data[DW-1:0] = DW'(idx + 1);
      else b_in_valid[0] = 1'b0;
    end
    tests_run++;
    if (bexp.size() != 0) begin
      tests_failed++; $display("FAIL burst_timeout: got %0d beats missing, need 0", bexp.size());
    end
    for (int p = 0; p < bcyc.size(); p++) begin
      if (p == 0 || bcyc[p] != bcyc[p-1] + 1) begin
        if (p > 0) begin
          tests_run++;
          if (bcyc[p] != bcyc[p-1] + 2) begin
            tests_failed++; $display("FAIL burst_bubble: got gap %0d, need 2", bcyc[p] - bcyc[p-1]);
          end
        end
        grp.push_back(1);
      end else begin
        grp[grp.size()-1]++;
      end
    end
    tests_run++;
    if (grp.size() != want.size()) begin
      tests_failed++; $display("FAIL burst_groups: got %0d groups, need %0d", grp.size(), want.size());
    end
    for (int g = 0; g < grp.size() && g < want.size(); g++) begin
      tests_run++;
      if (grp[g] != want[g]) begin
        tests_failed++; $display("FAIL burst_size%0d: got %0d, need %0d", g, grp[g], want[g]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    for (int k = 1; k <= 8; k++) push_beat(1, DW'(32'h100 + k), k == 8);
    drive();
    while (log_src.size() < 3 && n < 20) begin tick(); n++; end
    out_ready = 1'b0;
    repeat (6) begin
      tick();
      tests_run++;
      if (in_ready !== '0 || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_stall: got in_ready=%b out_valid=%0b, need 0000 1", in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    wait_idle(40, "bp");
    tests_run++;
    if (log_src.size() != 8) begin
      tests_failed++; $display("FAIL bp_count: got %0d beats, need 8", log_src.size());
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    push_beat(1, DW'(32'h0AA), 1'b1);
    for (int k = 1; k <= 5; k++) push_beat(1, DW'(32'h200 + k), k == 5);
    drive();
    while (log_src.size() < 3 && n < 30) begin tick(); n++; end
    #2;
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_pre: got out_valid=%0b, need 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got out_valid=%0b in_ready=%b, need 0 0000", out_valid, in_ready);
    end
    clear_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_beat(3, DW'(32'h333), 1'b1);
    push_beat(0, DW'(32'h000111), 1'b1);
    drive();
    wait_idle(30, "rstmid");
    tests_run++;
    if (log_src.size() != 2 || log_src[0] != 0 || log_src[1] != 3) begin
      tests_failed++;
      $display("FAIL rstmid_order: got %0d beats first src=%0d, need 2 beats src 0 then 3",
               log_src.size(), (log_src.size() > 0) ? log_src[0] : -1);
    end
  endtask

  task automatic test_valid_drop();
    int want [5] = '{1, 1, 2, 2, 1};
    do_reset();
    push_beat(1, DW'(32'h0A1), 1'b0);
    push_beat(1, DW'(32'h0A2), 1'b0);
    push_gap(1);
    push_beat(1, DW'(32'h0A3), 1'b1);
    push_beat(2, DW'(32'h0B1), 1'b0);
    push_beat(2, DW'(32'h0B2), 1'b1);
    drive();
    wait_idle(40, "drop");
    tests_run++;
    if (log_src.size() != 5) begin
      tests_failed++; $display("FAIL drop_count: got %0d beats, need 5", log_src.size());
    end
    for (int p = 0; p < log_src.size() && p < 5; p++) begin
      tests_run++;
      if (log_src[p] != want[p]) begin
        tests_failed++; $display("FAIL drop_src%0d: got %0d, need %0d", p, log_src[p], want[p]);
      end
    end
    if (log_cyc.size() >= 3) begin
      tests_run++;
      if (log_cyc[2] != log_cyc[1] + 3) begin
        tests_failed++; $display("FAIL drop_regrant: got gap %0d, need 3", log_cyc[2] - log_cyc[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_burst_split();
    test_backpressure();
    test_reset_mid();
`ifndef VRA_PKT_LOCK_EN
    test_valid_drop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, need finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vld_rdy_rr_arbiter.md
Name: vld_rdy_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream valid-ready pixel channel among NUM_REQ upstream valid-ready streams. Grants are burst-granular: a grant holds until the granted requester's frame/burst ends, so beats from different sources never interleave inside a burst. The output is registered and obeys the team's valid-ready rules: valid is never withdrawn without ready, and data is stable while valid is high and ready is low. It sits between the pixel producers and a single shared consumer such as a DMA write port.

Parameters:
DATA_WIDTH, 24, pixel bus width per stream.
NUM_REQ, 4, number of requesters; legal range 2..8.
BURST_LEN, 16, maximum beats per grant; legal range 1..255.
SEL_W, $clog2(NUM_REQ), localparam; width of the source index.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous reset, active low.
in_valid  input  NUM_REQ  per-requester valid.
in_ready  output  NUM_REQ  per-requester ready; at most one bit high.
in_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
in_last  input  NUM_REQ  per-requester last beat of frame.
out_valid  output  1  downstream valid.
out_ready  input  1  downstream ready.
out_data  output  DATA_WIDTH  downstream data.
out_last  output  1  last flag copied from the granted beat.
out_src  output  SEL_W  index of the requester that produced the current out beat.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs are 0; in_ready=0; state=IDLE; rr_ptr=0, so requester 0 has highest priority; beat_cnt=0.
- FSM states:
  - IDLE: if any in_valid is high, grant the first requester with in_valid high, searching from rr_ptr upward with wrap-around. Register grant_idx, go to GRANT, clear beat_cnt. No in_ready is asserted in IDLE.
  - GRANT: in_ready[grant_idx] = ~out_valid | out_ready. All other in_ready bits are 0.
- Output register:
  - On input accept (in_valid & in_ready of the granted requester): load out_data, out_last and out_src=grant_idx, and set out_valid=1.
  - Else if out_ready is high: clear out_valid. out_data holds its value.
- Latency and throughput:
  - Input accept to out_valid: 1 cycle.
  - Sustained throughput inside a grant: 1 beat/cycle.
  - Each re-arbitration costs exactly 1 bubble cycle (the IDLE cycle).
- Grant release: in GRANT, return to IDLE and set rr_ptr = (grant_idx+1) mod NUM_REQ on any of:
  - (a) an accepted beat with in_last=1;
  - (b) an accepted beat that brings beat_cnt to BURST_LEN;
  - (c) a cycle where in_valid[grant_idx]=0 (idle release).
- beat_cnt: 8 bits. Increments on each accepted beat and clears on entry to GRANT.
- Simultaneous events:
  - Downstream pop and upstream push in the same cycle: both take effect; out_valid stays 1 and the new beat is loaded.
  - Release and a new request in the same cycle: the new request waits for the IDLE cycle.
- Requester deasserting in_valid without a transfer: this is a protocol violation upstream. The arbiter does not check it; it simply applies release rule (c).
- out_valid high with out_ready low: out_data, out_last and out_src hold stable. The output register is not reloaded because in_ready is low.
- Reset mid-burst: the burst is dropped, out_valid drops to 0 immediately, and arbitration restarts from requester 0.
- in_data of non-granted requesters is ignored.

Optional Feature:
Macro VRA_PKT_LOCK_EN.
- Defined: grant is held strictly until an accepted beat with in_last=1. Release rules (b) and (c) are removed; beat_cnt is still maintained. This guarantees whole-frame atomicity.
- Undefined: all three release rules (a), (b) and (c) apply, as above.

Test Plan:
- Reset, then only requester 2 streams 5 beats 0x000001..0x000005 with last on beat 5, out_ready=1 -> out_valid rises 2 cycles after the first in_valid (IDLE + register); 5 contiguous beats appear with out_src=2 and out_last on 0x000005.
- All 4 requesters valid continuously with 3-beat frames -> grant order 0,1,2,3,0; one bubble between frames; no interleaving inside a frame.
- Single requester, BURST_LEN=4, 10-beat frame without in_last -> bursts of 4,4,2 split by 1 bubble each. With VRA_PKT_LOCK_EN defined -> 10 contiguous beats.
- out_ready held low for 6 cycles mid-burst -> out_data/out_last/out_src stable, in_ready=0, no beat lost or duplicated. Run this case with vld_rdy_checker attached to the out port.
- rst_n pulsed low in the middle of beat 3 of a 5-beat frame -> out_valid=0 and in_ready=0 asynchronously; after release, requester 0 is granted first.
- Requester 1 drops in_valid mid-frame (flag undefined) -> grant is released the same cycle and requester 2 is granted after one IDLE cycle.
